pcm_stream_ctrl: RTL and testbench
==================================

Name: pcm_stream_ctrl

Overview:
Sequencer between the SD-card SPI byte stream and the audio path. Packs incoming bytes into 16-bit little-endian PCM words and writes them to the sample FIFO, applying backpressure to the SD reader. Prefills the FIFO before playback, then pops one sample per sample-rate tick into the DAC. Detects end-of-stream and underrun, and reports completion.

Parameters:
TICK_DIV, 1042, sample period in clk_i cycles (50 MHz / 1042 ≈ 48 kHz); must be ≥4
LEN_W, 32, width of byte-length counter
SILENCE, 16'h8000, midscale offset-binary sample output when no data is available

Ports:
clk_i  in  1  system clock (50 MHz)
reset_i  in  1  asynchronous, active-low reset
start_i  in  1  begin a stream; honoured only in IDLE or DONE
total_bytes_i  in  LEN_W  stream length in bytes, sampled on the accepted start
byte_i  in  8  data byte from SD reader
byte_val_i  in  1  single-cycle strobe, byte_i valid
byte_hold_o  out  1  backpressure to SD reader
fifo_clr_o  out  1  one-cycle FIFO flush pulse
fifo_din_o  out  16  packed word to FIFO
fifo_wr_en_o  out  1  FIFO write strobe
fifo_prog_full_i  in  1  FIFO programmable-full
fifo_empty_i  in  1  FIFO empty
fifo_rd_en_o  out  1  FIFO read strobe (standard mode, dout valid 1 cycle later)
fifo_dout_i  in  16  FIFO read data
pcm_o  out  16  sample to DAC
sample_tick_o  out  1  one-cycle pulse per sample period (PLAY/DRAIN only)
busy_o  out  1  high in FILL, PLAY, DRAIN
dat_done_o  out  1  stream complete
underrun_o  out  1  sticky underrun flag, cleared on accepted start

Behaviour:
- Reset values: byte_hold_o=1, pcm_o=SILENCE, every other output 0; state IDLE; counters 0. Reset is legal at any time, including mid-PLAY: the state machine and counters return to reset values and no write is completed.
- States: IDLE, FILL, PLAY, DRAIN, DONE. All outputs are registered.
- IDLE/DONE + start_i -> FILL:
  - latch total_bytes_i
  - clear byte count, packing phase and underrun_o
  - pulse fifo_clr_o for 1 cycle
  - dat_done_o drops to 0
- start_i in FILL/PLAY/DRAIN is ignored.
- Byte acceptance: only in FILL/PLAY and only while byte count < latched total. Bytes arriving outside these conditions are dropped. Bytes arriving while byte_hold_o=1 are still accepted (covers an in-flight byte).
- Packing: an even-index byte goes to the low byte register. An odd-index byte forms {byte_i, low}, and the word is written with fifo_wr_en_o=1 on the cycle after the strobe.
  - If the final byte has an even index (odd total), {8'h00, low} is written on the cycle after that byte.
- byte_hold_o = 1 unless state is FILL or PLAY; also 1 whenever fifo_prog_full_i=1 (registered, so it lags by 1 cycle).
- FILL -> PLAY when fifo_prog_full_i=1 or byte count == total. The tick counter is cleared on entry.
- Tick counter: counts 0..TICK_DIV-1 in PLAY/DRAIN. sample_tick_o is asserted on the cycle the counter wraps, so the first tick comes TICK_DIV cycles after entering PLAY.
- On tick with fifo_empty_i=0: fifo_rd_en_o=1 in the same cycle as sample_tick_o. pcm_o <= fifo_dout_i at the edge ending the following cycle, i.e. visible 2 cycles after rd_en.
- On tick with fifo_empty_i=1:
  - PLAY: set underrun_o; pcm_o <= SILENCE on the next edge.
  - DRAIN: go to DONE.
- PLAY -> DRAIN once byte count == total and the final write has been issued.
- DONE: dat_done_o=1, pcm_o=SILENCE, no FIFO accesses. Held until start_i.
- A FIFO write and a read in the same cycle are allowed.
- total_bytes_i=0: FILL -> PLAY -> DRAIN immediately; DONE at the first tick.

Decomposition:
- Package pcm_stream_pkg: state enum, SILENCE default, TICK_DIV default.
- One sub-module, sample_tick_gen: parameter TICK_DIV, inputs clk_i/reset_i/run, output tick. The counter is cleared whenever run=0.
- Packing, handshake and FSM stay in pcm_stream_ctrl.

Test Plan:
- Reset asserted mid-PLAY -> next cycle byte_hold_o=1, pcm_o=16'h8000, fifo_wr_en_o=0, state IDLE; start again -> single fifo_clr_o pulse.
- TICK_DIV=8, total=4, bytes 34,12,78,56 -> FIFO writes 16'h1234 then 16'h5678, each one cycle after the 2nd/4th strobe; DRAIN entered.
- total=3, bytes AA,BB,CC -> writes 16'hBBAA, 16'h00CC; a 4th strobe is ignored (no write).
- prog_full raised after 2 words -> no rd_en before; byte_hold_o=1 one cycle later; first sample_tick_o 8 cycles after PLAY entry; pcm_o=first word 2 cycles after rd_en.
- PLAY with FIFO empty at a tick, bytes outstanding -> underrun_o=1 (sticky), pcm_o=16'h8000, no rd_en; underrun_o clears on the next accepted start.
- Stream of 2 words fully drained -> dat_done_o=1 at the first empty tick in DRAIN; start_i in DONE -> FILL, dat_done_o=0.

Source files
------------

// File: rtl/pcm_stream_pkg.sv
// pcm_stream_pkg: shared state encoding and default parameters for the PCM stream sequencer
package pcm_stream_pkg;
    typedef enum logic [2:0] {S_IDLE, S_FILL, S_PLAY, S_DRAIN, S_DONE} state_t;
    localparam int          TICK_DIV_DEF = 1042;
    localparam logic [15:0] SILENCE_DEF  = 16'h8000;
endpackage

// File: rtl/sample_tick_gen.sv
// sample_tick_gen: one-cycle pulse every TICK_DIV cycles while run is high
// Ports: clk_i clock; reset_i async active-low reset; run enables counting
//        (counter held at 0 when low); tick registered pulse on counter wrap.
module sample_tick_gen
    import pcm_stream_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEF
)(
    input  logic clk_i,
    input  logic reset_i,
    input  logic run,
    output logic tick
);
    localparam int CW = $clog2(TICK_DIV);

    logic [CW-1:0] r_cnt;
    logic          r_tick;
    logic          w_wrap;

    assign w_wrap = r_cnt == CW'(TICK_DIV - 1);
    assign tick   = r_tick;

    // The tick is registered, so it lands on the cycle the counter reads 0 again,
    // i.e. exactly TICK_DIV cycles after run rises.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= run && w_wrap;
            r_cnt  <= (!run || w_wrap) ? '0 : r_cnt + CW'(1);
        end
    end
endmodule

// File: rtl/pcm_stream_ctrl.sv
// pcm_stream_ctrl: packs SD bytes into 16-bit LE words for the sample FIFO and plays them out per sample tick
// Ports: clk_i/reset_i clock and async active-low reset; start_i/total_bytes_i stream start and length;
//        byte_i/byte_val_i/byte_hold_o SD byte stream with backpressure; fifo_* sample FIFO write/read/flush
//        and status; pcm_o DAC sample; sample_tick_o sample pulse; busy_o/dat_done_o/underrun_o status.
module pcm_stream_ctrl
    import pcm_stream_pkg::*;
#(
    parameter int          TICK_DIV = TICK_DIV_DEF,
    parameter int          LEN_W    = 32,
    parameter logic [15:0] SILENCE  = SILENCE_DEF
)(
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [LEN_W-1:0] total_bytes_i,
    input  logic [7:0]       byte_i,
    input  logic             byte_val_i,
    output logic             byte_hold_o,
    output logic             fifo_clr_o,
    output logic [15:0]      fifo_din_o,
    output logic             fifo_wr_en_o,
    input  logic             fifo_prog_full_i,
    input  logic             fifo_empty_i,
    output logic             fifo_rd_en_o,
    input  logic [15:0]      fifo_dout_i,
    output logic [15:0]      pcm_o,
    output logic             sample_tick_o,
    output logic             busy_o,
    output logic             dat_done_o,
    output logic             underrun_o
);
    state_t           r_state, w_next;
    logic [LEN_W-1:0] r_total, r_cnt, w_cnt_inc;
    logic [7:0]       r_low;
    logic [15:0]      r_din, r_pcm;
    logic             r_hold, r_clr, r_wr, r_busy, r_done, r_under, r_rd_d;
    logic             w_tick, w_run, w_start, w_acc, w_last, w_empty_tick, w_feed, w_next_feed;

    assign w_run        = r_state == S_PLAY || r_state == S_DRAIN;
    assign w_feed       = r_state == S_FILL || r_state == S_PLAY;
    assign w_next_feed  = w_next == S_FILL || w_next == S_PLAY;
    assign w_start      = start_i && (r_state == S_IDLE || r_state == S_DONE);
    assign w_acc        = byte_val_i && w_feed && r_cnt < r_total;
    assign w_last       = r_cnt == r_total;
    assign w_cnt_inc    = r_cnt + LEN_W'(1);
    assign w_empty_tick = w_tick && w_run && fifo_empty_i;

    assign byte_hold_o   = r_hold;
    assign fifo_clr_o    = r_clr;
    assign fifo_din_o    = r_din;
    assign fifo_wr_en_o  = r_wr;
    assign pcm_o         = r_pcm;
    assign sample_tick_o = w_tick;
    assign busy_o        = r_busy;
    assign dat_done_o    = r_done;
    assign underrun_o    = r_under;
    // Read strobe shares the cycle of the registered tick; it only gates that pulse with the empty flag.
    assign fifo_rd_en_o  = w_tick && w_run && !fifo_empty_i;

    sample_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .run     (w_run),
        .tick    (w_tick)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (start_i) w_next = S_FILL;
            S_FILL:         if (fifo_prog_full_i || w_last) w_next = S_PLAY;
            S_PLAY:         if (w_last) w_next = S_DRAIN;
            S_DRAIN:        if (w_empty_tick) w_next = S_DONE;
            default:        w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state <= S_IDLE;
            r_total <= '0;
            r_cnt   <= '0;
            r_low   <= '0;
            r_din   <= '0;
            r_pcm   <= SILENCE;
            r_hold  <= 1'b1;
            r_clr   <= 1'b0;
            r_wr    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_under <= 1'b0;
            r_rd_d  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_clr   <= w_start;
            r_hold  <= !w_next_feed || fifo_prog_full_i;
            r_busy  <= w_next == S_FILL || w_next == S_PLAY || w_next == S_DRAIN;
            r_done  <= w_next == S_DONE;
            r_rd_d  <= fifo_rd_en_o;
            r_wr    <= 1'b0;
            if (w_start) begin
                r_total <= total_bytes_i;
                r_cnt   <= '0;
                r_under <= 1'b0;
            end else if (w_acc) begin
                r_cnt <= w_cnt_inc;
                // r_cnt[0] is the packing phase: odd index completes a word,
                // an even index that is also the last byte flushes a zero-padded word.
                if (r_cnt[0]) begin
                    r_din <= {byte_i, r_low};
                    r_wr  <= 1'b1;
                end else begin
                    r_low <= byte_i;
                    if (w_cnt_inc == r_total) begin
                        r_din <= {8'h00, byte_i};
                        r_wr  <= 1'b1;
                    end
                end
            end
            if (r_state == S_PLAY && w_empty_tick) begin
                r_under <= 1'b1;
                r_pcm   <= SILENCE;
            end else if (w_next == S_DONE) begin
                r_pcm <= SILENCE;
            end else if (r_rd_d && w_run) begin
                r_pcm <= fifo_dout_i;
            end
        end
    end
endmodule

// File: tb/tb_pcm_stream_ctrl.sv
// tb_pcm_stream_ctrl: randomized and directed self-checking bench with a behavioural stream/FIFO model
module tb_pcm_stream_ctrl;
    localparam int TD = 8;
    localparam logic [15:0] SIL = 16'h8000;

    logic        clk = 1'b0, reset_i = 1'b1, start_i = 1'b0, byte_val_i = 1'b0;
    logic [31:0] total_bytes_i = '0;
    logic [7:0]  byte_i = '0;
    logic        fifo_prog_full_i = 1'b0, fifo_empty_i = 1'b1;
    logic [15:0] fifo_dout_i = '0;
    logic        byte_hold_o, fifo_clr_o, fifo_wr_en_o, fifo_rd_en_o, sample_tick_o, busy_o, dat_done_o, underrun_o;
    logic [15:0] fifo_din_o, pcm_o;

    int checks = 0, failures = 0;

    // Model: mode 0 idle, 1 fill, 2 play, 3 drain, 4 done
    int          m_mode, m_total, m_cnt, m_age, m_wr, m_rd, m_thr;
    bit          m_rd_last;
    logic [15:0] m_last_word;
    logic [7:0]  m_bytes[$];
    logic [15:0] m_words[$];
    bit          e_hold, e_clr, e_wr, e_tick, e_busy, e_done, e_under;
    logic [15:0] e_din, e_pcm;

    always #5 clk = ~clk;

    pcm_stream_ctrl #(.TICK_DIV(TD), .LEN_W(32), .SILENCE(SIL)) dut (
        .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .total_bytes_i(total_bytes_i),
        .byte_i(byte_i), .byte_val_i(byte_val_i), .byte_hold_o(byte_hold_o),
        .fifo_clr_o(fifo_clr_o), .fifo_din_o(fifo_din_o), .fifo_wr_en_o(fifo_wr_en_o),
        .fifo_prog_full_i(fifo_prog_full_i), .fifo_empty_i(fifo_empty_i),
        .fifo_rd_en_o(fifo_rd_en_o), .fifo_dout_i(fifo_dout_i), .pcm_o(pcm_o),
        .sample_tick_o(sample_tick_o), .busy_o(busy_o), .dat_done_o(dat_done_o),
        .underrun_o(underrun_o)
    );

    task automatic chk(string n, logic [31:0] a, logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", n, a, e, $time);
        end
    endtask

    task automatic drive_fifo();
        fifo_empty_i     = (m_wr - m_rd) == 0;
        fifo_prog_full_i = (m_wr - m_rd) >= m_thr;
        fifo_dout_i      = m_last_word;
    endtask

    task automatic model_reset();
        m_mode = 0; m_total = 0; m_cnt = 0; m_age = 0; m_wr = 0; m_rd = 0;
        m_rd_last = 0; m_last_word = '0;
        m_bytes.delete(); m_words.delete();
        e_hold = 1; e_clr = 0; e_wr = 0; e_din = '0; e_pcm = SIL;
        e_tick = 0; e_busy = 0; e_done = 0; e_under = 0;
        drive_fifo();
    endtask

    task automatic compare();
        chk("hold", byte_hold_o, e_hold);
        chk("clr", fifo_clr_o, e_clr);
        chk("wr_en", fifo_wr_en_o, e_wr);
        chk("din", fifo_din_o, e_din);
        chk("rd_en", fifo_rd_en_o, e_tick && (m_wr - m_rd) != 0);
        chk("pcm", pcm_o, e_pcm);
        chk("tick", sample_tick_o, e_tick);
        chk("busy", busy_o, e_busy);
        chk("done", dat_done_o, e_done);
        chk("underrun", underrun_o, e_under);
    endtask

    // Inputs for the current cycle are already driven; advance model and DUT one clock and compare.
    task automatic step();
        int          occ  = m_wr - m_rd;
        bit          run  = m_mode == 2 || m_mode == 3;
        bit          rd   = e_tick && occ != 0;
        bit          etk  = e_tick && occ == 0;
        bit          st   = start_i && (m_mode == 0 || m_mode == 4);
        bit          acc  = byte_val_i && (m_mode == 1 || m_mode == 2) && m_cnt < m_total;
        bit          pf   = occ >= m_thr;
        int          nm   = m_mode;
        bit          nw   = 0;
        logic [15:0] nd   = e_din;
        logic [15:0] np   = e_pcm;
        case (m_mode)
            0, 4: if (start_i) nm = 1;
            1:    if (pf || m_cnt == m_total) nm = 2;
            2:    if (m_cnt == m_total) nm = 3;
            3:    if (etk) nm = 4;
            default: nm = 0;
        endcase
        if (m_mode == 2 && etk) np = SIL;
        else if (nm == 4) np = SIL;
        else if (m_rd_last && run) np = m_last_word;
        if (e_wr) m_wr++;
        m_rd_last = rd;
        if (rd) begin
            m_last_word = m_words[m_rd];
            m_rd++;
        end
        if (acc) begin
            m_bytes.push_back(byte_i);
            if (m_cnt % 2 == 1) begin
                nw = 1; nd = {byte_i, m_bytes[m_cnt-1]};
            end else if (m_cnt + 1 == m_total) begin
                nw = 1; nd = {8'h00, byte_i};
            end
            if (nw) m_words.push_back(nd);
            m_cnt++;
        end
        e_under = st ? 1'b0 : (e_under || (m_mode == 2 && etk));
        if (st) begin
            m_total = int'(total_bytes_i); m_cnt = 0; m_wr = 0; m_rd = 0;
            m_bytes.delete(); m_words.delete();
        end
        m_age  = (nm == 2 || nm == 3) ? (run ? m_age + 1 : 0) : 0;
        e_tick = (nm == 2 || nm == 3) && m_age > 0 && m_age % TD == 0;
        e_hold = !(nm == 1 || nm == 2) || pf;
        e_clr  = st; e_wr = nw; e_din = nd; e_pcm = np;
        e_busy = nm >= 1 && nm <= 3; e_done = nm == 4;
        m_mode = nm;
        @(posedge clk); #1;
        drive_fifo();
        @(negedge clk);
        compare();
    endtask

    task automatic send_byte(logic [7:0] b);
        byte_i = b; byte_val_i = 1; step(); byte_val_i = 0;
    endtask

    task automatic start(int t);
        total_bytes_i = t; start_i = 1; step(); start_i = 0;
    endtask

    task automatic do_reset();
        start_i = 0; byte_val_i = 0;
        reset_i = 0;
        model_reset();
        @(negedge clk);
        compare();
        chk("rst_hold", byte_hold_o, 1);
        chk("rst_pcm", pcm_o, SIL);
        chk("rst_wr", fifo_wr_en_o, 0);
        chk("rst_busy", busy_o, 0);
        reset_i = 1;
    endtask

    task automatic run_until_done(int lim);
        for (int c = 0; c < lim && m_mode != 4; c++) step();
        chk("done_reached", dat_done_o, 1);
    endtask

    initial begin
        int n, rst_at;
        m_thr = 100;
        model_reset();
        #1 reset_i = 0;
        @(negedge clk);
        compare();
        chk("init_hold", byte_hold_o, 1);
        chk("init_pcm", pcm_o, SIL);
        reset_i = 1;

        // Even-length stream: two words, one cycle after each completing strobe
        start(4);
        chk("clr_pulse", fifo_clr_o, 1);
        send_byte(8'h34); send_byte(8'h12);
        chk("w1_en", fifo_wr_en_o, 1);
        chk("w1_din", fifo_din_o, 16'h1234);
        send_byte(8'h78); send_byte(8'h56);
        chk("w2_en", fifo_wr_en_o, 1);
        chk("w2_din", fifo_din_o, 16'h5678);
        n = 0;
        while (!sample_tick_o && n < 40) begin step(); n++; end
        chk("tick_latency", n, 9);
        chk("rd_on_tick", fifo_rd_en_o, 1);
        step(); step();
        chk("pcm_w1", pcm_o, 16'h1234);
        run_until_done(100);
        chk("done_pcm", pcm_o, SIL);

        // Odd-length stream: zero-padded final word, extra strobe dropped
        start(3);
        chk("done_drop", dat_done_o, 0);
        chk("clr2", fifo_clr_o, 1);
        send_byte(8'hAA); send_byte(8'hBB);
        chk("w3_din", fifo_din_o, 16'hBBAA);
        send_byte(8'hCC);
        chk("w4_en", fifo_wr_en_o, 1);
        chk("w4_din", fifo_din_o, 16'h00CC);
        send_byte(8'hDD);
        chk("no_4th_wr", fifo_wr_en_o, 0);
        run_until_done(100);

        // Prog-full prefill, then underrun while bytes are still owed
        m_thr = 2; drive_fifo();
        start(8);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        step();
        chk("hold_before_pf", byte_hold_o, 0);
        step();
        chk("hold_pf_lag", byte_hold_o, 1);
        n = 0;
        while (!underrun_o && n < 80) begin step(); n++; end
        chk("underrun_set", underrun_o, 1);
        chk("underrun_pcm", pcm_o, SIL);
        for (int i = 0; i < 4; i++) begin send_byte(8'h10 + 8'(i)); step(); end
        run_until_done(200);
        chk("underrun_sticky", underrun_o, 1);
        start(6);
        chk("underrun_clr", underrun_o, 0);

        // Reset in the middle of playback, then a zero-length stream
        send_byte(8'h21); send_byte(8'h22); send_byte(8'h23); send_byte(8'h24);
        step(); step(); step();
        chk("in_play", busy_o, 1);
        do_reset();
        start(0);
        chk("clr_after_rst", fifo_clr_o, 1);
        step();
        chk("clr_single", fifo_clr_o, 0);
        run_until_done(50);

        // Randomized streams with stray starts, random prog-full depth and occasional resets
        for (int s = 0; s < 30; s++) begin
            m_thr = $urandom_range(2, 8); drive_fifo();
            start($urandom_range(0, 24));
            rst_at = ($urandom % 6 == 0) ? int'($urandom_range(5, 60)) : -1;
            for (int c = 0; c < 3000 && m_mode != 4; c++) begin
                if (c == rst_at) begin do_reset(); break; end
                byte_val_i    = ($urandom % 3) == 0;
                byte_i        = 8'($urandom);
                start_i       = ($urandom % 40) == 0;
                total_bytes_i = $urandom_range(0, 24);
                step();
            end
            byte_val_i = 0; start_i = 0;
            if (rst_at < 0) chk("rand_done", dat_done_o, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1);
    end
endmodule
